// File: rtl/dnn_dot_ctrl.sv
// dnn_dot_ctrl: CSR-configured fixed-point dot-product engine mastering SDRAM over Avalon-MM
module dnn_dot_ctrl #(
   parameter int FRAC  = 16,
   parameter int LEN_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   output logic [31:0] slave_readdata,
   output logic [31:0] master_address,
   output logic        master_read,
   output logic        master_write,
   output logic [31:0] master_writedata,
   input  logic [31:0] master_readdata,
   input  logic        master_waitrequest,
   input  logic        master_readdatavalid
);
   typedef enum logic [2:0] {IDLE, RD_W, WT_W, RD_I, WT_I, MAC, WR} state_t;
   state_t state, nxt;
   logic [31:0] waddr, iaddr, oaddr, bias, result, acc, w, a, term, sum, res, off;
   logic [LEN_W-1:0] len, i;
   logic [LEN_W:0] i_nxt;
   logic relu, busy, start, accepted, more;
   assign busy = state != IDLE;
   assign start = slave_write && slave_address == 3'd0 && !busy;
   assign accepted = !master_waitrequest;
   assign term = 32'((64'($signed(w)) * 64'($signed(a))) >>> FRAC);
   assign sum = acc + bias;
   assign res = (relu && sum[31]) ? '0 : sum;
   assign off = 32'(i) << 2;
   assign i_nxt = {1'b0, i} + {{LEN_W{1'b0}}, 1'b1};
   assign more = i_nxt < {1'b0, len};
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   // next-state: one request at a time, each read waits for its data before the next
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = (len == '0) ? WR : RD_W;
         RD_W: if (accepted) nxt = WT_W;
         WT_W: if (master_readdatavalid) nxt = RD_I;
         RD_I: if (accepted) nxt = WT_I;
         WT_I: if (master_readdatavalid) nxt = MAC;
         MAC:  nxt = more ? RD_W : WR;
         WR:   if (accepted) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // master outputs derive from state and frozen registers, so they hold still under stall
   always_comb begin
      master_read = state == RD_W || state == RD_I;
      master_write = state == WR;
      master_address = (state == RD_W) ? waddr + off :
                       (state == RD_I) ? iaddr + off :
                       (state == WR)   ? oaddr : '0;
      master_writedata = (state == WR) ? res : '0;
   end
   // datapath: operand capture, accumulate with truncated Q-format product, result latch
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         i <= '0;
         w <= '0;
         a <= '0;
         result <= '0;
      end else begin
         if (start) begin
            acc <= '0;
            i <= '0;
         end
         if (state == WT_W && master_readdatavalid) w <= master_readdata;
         if (state == WT_I && master_readdatavalid) a <= master_readdata;
         if (state == MAC) begin
            acc <= acc + term;
            i <= i_nxt[LEN_W-1:0];
         end
         if (state == WR && accepted) result <= res;
      end
   // configuration registers, frozen while a run is in progress
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         waddr <= '0;
         iaddr <= '0;
         oaddr <= '0;
         len <= '0;
         bias <= '0;
         relu <= 1'b0;
      end else if (slave_write && !busy) begin
         case (slave_address)
            3'd1: waddr <= slave_writedata;
            3'd2: iaddr <= slave_writedata;
            3'd3: oaddr <= slave_writedata;
            3'd4: len <= slave_writedata[LEN_W-1:0];
            3'd5: bias <= slave_writedata;
            3'd6: relu <= slave_writedata[0];
            default: ;
         endcase
      end
   // CSR read mux, zero wait
   always_comb begin
      slave_readdata = '0;
      if (slave_read)
         case (slave_address)
            3'd0: slave_readdata = {31'b0, busy};
            3'd1: slave_readdata = waddr;
            3'd2: slave_readdata = iaddr;
            3'd3: slave_readdata = oaddr;
            3'd4: slave_readdata = 32'(len);
            3'd5: slave_readdata = bias;
            3'd6: slave_readdata = {31'b0, relu};
            default: slave_readdata = result;
         endcase
   end
endmodule

// File: tb/tb_dnn_dot_ctrl.sv
// tb_dnn_dot_ctrl: directed checks of dnn_dot_ctrl against a stalling Avalon memory model
module tb_dnn_dot_ctrl;
   logic clk = 0, rst_n = 1;
   logic [2:0] slave_address = '0;
   logic slave_read = 0, slave_write = 0;
   logic [31:0] slave_writedata = '0, slave_readdata;
   logic [31:0] master_address, master_writedata, master_readdata;
   logic master_read, master_write, master_waitrequest, master_readdatavalid;
   int vectors = 0, errs = 0;
   logic [31:0] mem [0:255];
   int stall_max = 0, lat_min = 1, lat_max = 1;
   int st_cnt, lat, rd_count = 0, wr_count = 0, proto_err = 0;
   logic pend, held, h_rd, h_wr;
   logic [31:0] p_addr, h_addr, h_data, wr_addr, wr_data;

   always #5 clk = ~clk;

   dnn_dot_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
      .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
      .master_address(master_address), .master_read(master_read), .master_write(master_write),
      .master_writedata(master_writedata), .master_readdata(master_readdata),
      .master_waitrequest(master_waitrequest), .master_readdatavalid(master_readdatavalid)
   );

   assign master_waitrequest = (master_read || master_write) && st_cnt != 0;

   // memory slave: random stalls, random read latency, protocol monitoring
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pend <= 0;
         held <= 0;
         st_cnt <= 0;
         master_readdatavalid <= 0;
         master_readdata <= '0;
      end else begin
         master_readdatavalid <= 0;
         if (pend) begin
            if (lat <= 1) begin
               master_readdatavalid <= 1;
               master_readdata <= mem[p_addr[9:2]];
               pend <= 0;
            end else lat <= lat - 1;
         end
         if (held && (master_address !== h_addr || master_read !== h_rd || master_write !== h_wr ||
                      (h_wr && master_writedata !== h_data)))
            proto_err <= proto_err + 1;
         held <= master_waitrequest;
         h_addr <= master_address;
         h_data <= master_writedata;
         h_rd <= master_read;
         h_wr <= master_write;
         if (master_read || master_write) begin
            if (pend || (master_read && master_write)) proto_err <= proto_err + 1;
            if (st_cnt != 0) st_cnt <= st_cnt - 1;
            else begin
               if (master_read) begin
                  rd_count <= rd_count + 1;
                  pend <= 1;
                  p_addr <= master_address;
                  lat <= $urandom_range(lat_max, lat_min);
               end else begin
                  wr_count <= wr_count + 1;
                  wr_addr <= master_address;
                  wr_data <= master_writedata;
               end
               st_cnt <= $urandom_range(stall_max, 0);
            end
         end
      end

   task automatic csr_wr(input logic [2:0] ad, input logic [31:0] d);
      @(negedge clk);
      slave_address = ad;
      slave_writedata = d;
      slave_write = 1;
      @(negedge clk);
      slave_write = 0;
   endtask

   task automatic csr_rd(input logic [2:0] ad, output logic [31:0] d);
      @(negedge clk);
      slave_address = ad;
      slave_read = 1;
      #1 d = slave_readdata;
      slave_read = 0;
   endtask

   task automatic wait_idle(output bit to);
      logic [31:0] d;
      to = 1;
      for (int k = 0; k < 2000; k++) begin
         csr_rd(3'd0, d);
         if (d[0] == 1'b0) begin
            to = 0;
            return;
         end
      end
   endtask

   task automatic setup(input logic [31:0] wa, ia, oa, ln, bs, rl);
      csr_wr(3'd1, wa);
      csr_wr(3'd2, ia);
      csr_wr(3'd3, oa);
      csr_wr(3'd4, ln);
      csr_wr(3'd5, bs);
      csr_wr(3'd6, rl);
   endtask

   task automatic load_basic();
      mem[8'h40] = 32'h0001_0000; mem[8'h41] = 32'h0002_0000; mem[8'h42] = 32'hFFFF_8000;
      mem[8'h80] = 32'h0004_0000; mem[8'h81] = 32'h0000_8000; mem[8'h82] = 32'h0002_0000;
   endtask

   task automatic run(output bit to, output int nrd, output int nwr);
      int r0, w0;
      r0 = rd_count;
      w0 = wr_count;
      csr_wr(3'd0, 32'd1);
      wait_idle(to);
      nrd = rd_count - r0;
      nwr = wr_count - w0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      @(negedge clk);
      vectors++;
      if ({master_read, master_write, master_address, master_writedata} !== 66'd0) begin
         errs++;
         $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h data=%h want all 0", master_read, master_write, master_address, master_writedata);
      end
      for (int k = 0; k < 8; k++) begin
         csr_rd(3'(k), d);
         vectors++;
         if (d !== 32'd0) begin
            errs++;
            $display("FAIL reset_csr%0d: got %h want 0", k, d);
         end
      end
   endtask

   task automatic test_basic();
      bit to;
      int r0, w0;
      logic [31:0] d;
      load_basic();
      setup(32'h100, 32'h200, 32'h300, 3, 32'h0000_4000, 0);
      r0 = rd_count;
      w0 = wr_count;
      csr_wr(3'd0, 32'd1);
      csr_rd(3'd0, d);
      vectors++;
      if (d !== 32'd1) begin errs++; $display("FAIL basic_busy_set: got %h want 1", d); end
      wait_idle(to);
      vectors++;
      if (to) begin errs++; $display("FAIL basic_timeout: got timeout want done"); end
      vectors++;
      if (wr_data !== 32'h0004_4000) begin errs++; $display("FAIL basic_wdata: got %h want 00044000", wr_data); end
      vectors++;
      if (wr_addr !== 32'h300) begin errs++; $display("FAIL basic_waddr: got %h want 00000300", wr_addr); end
      vectors++;
      if (rd_count - r0 !== 6 || wr_count - w0 !== 1) begin
         errs++;
         $display("FAIL basic_counts: got rd=%0d wr=%0d want rd=6 wr=1", rd_count - r0, wr_count - w0);
      end
      csr_rd(3'd7, d);
      vectors++;
      if (d !== 32'h0004_4000) begin errs++; $display("FAIL basic_result_csr: got %h want 00044000", d); end
   endtask

   task automatic test_relu();
      logic [31:0] bs [3] = '{32'hFFF8_0000, 32'hFFF8_0000, 32'hFFF8_4000};
      logic [31:0] rl [3] = '{32'd1, 32'd0, 32'd0};
      logic [31:0] ex [3] = '{32'h0000_0000, 32'hFFFC_0000, 32'hFFFC_4000};
      bit to;
      int nrd, nwr;
      load_basic();
      for (int k = 0; k < 3; k++) begin
         setup(32'h100, 32'h200, 32'h300, 3, bs[k], rl[k]);
         run(to, nrd, nwr);
         vectors++;
         if (to || nwr !== 1 || wr_data !== ex[k]) begin
            errs++;
            $display("FAIL relu_%0d: got to=%0d wr=%0d data=%h want to=0 wr=1 data=%h", k, to, nwr, wr_data, ex[k]);
         end
      end
   endtask

   task automatic test_len_zero();
      bit to;
      int nrd, nwr;
      setup(32'h100, 32'h200, 32'h340, 0, 32'h1234_5678, 0);
      run(to, nrd, nwr);
      vectors++;
      if (to || nrd !== 0 || nwr !== 1) begin
         errs++;
         $display("FAIL len0_counts: got to=%0d rd=%0d wr=%0d want to=0 rd=0 wr=1", to, nrd, nwr);
      end
      vectors++;
      if (wr_data !== 32'h1234_5678 || wr_addr !== 32'h340) begin
         errs++;
         $display("FAIL len0_write: got %h@%h want 12345678@00000340", wr_data, wr_addr);
      end
   endtask

   task automatic test_trunc();
      bit to;
      int nrd, nwr;
      mem[8'h40] = 32'hFFFF_8000;
      mem[8'h80] = 32'h0000_0003;
      setup(32'h100, 32'h200, 32'h300, 1, 0, 0);
      run(to, nrd, nwr);
      vectors++;
      if (to || wr_data !== 32'hFFFF_FFFE) begin
         errs++;
         $display("FAIL trunc_floor: got to=%0d data=%h want FFFFFFFE", to, wr_data);
      end
   endtask

   task automatic test_addr_wrap();
      bit to;
      int nrd, nwr;
      mem[8'hFF] = 32'h0003_0000; mem[8'h00] = 32'hFFFF_0000;
      mem[8'h80] = 32'h0000_8000; mem[8'h81] = 32'h0000_4000;
      setup(32'hFFFF_FFFC, 32'h200, 32'h300, 2, 0, 0);
      run(to, nrd, nwr);
      vectors++;
      if (to || nrd !== 4 || wr_data !== 32'h0001_4000) begin
         errs++;
         $display("FAIL addr_wrap: got to=%0d rd=%0d data=%h want to=0 rd=4 data=00014000", to, nrd, wr_data);
      end
   endtask

   task automatic test_stalls();
      bit to;
      int nrd, nwr, p0;
      p0 = proto_err;
      stall_max = 7;
      lat_min = 1;
      lat_max = 5;
      load_basic();
      setup(32'h100, 32'h200, 32'h300, 3, 32'h0000_4000, 0);
      for (int k = 0; k < 4; k++) begin
         run(to, nrd, nwr);
         vectors++;
         if (to || nrd !== 6 || nwr !== 1 || wr_data !== 32'h0004_4000) begin
            errs++;
            $display("FAIL stall_run%0d: got to=%0d rd=%0d wr=%0d data=%h want 0/6/1/00044000", k, to, nrd, nwr, wr_data);
         end
      end
      vectors++;
      if (proto_err - p0 !== 0) begin
         errs++;
         $display("FAIL stall_protocol: got %0d violations want 0", proto_err - p0);
      end
   endtask

   task automatic test_busy_writes();
      bit to;
      int r0;
      logic [31:0] d;
      load_basic();
      setup(32'h100, 32'h200, 32'h300, 3, 32'h0000_4000, 0);
      r0 = rd_count;
      csr_wr(3'd0, 32'd1);
      csr_wr(3'd4, 32'd1);
      csr_wr(3'd5, 32'd0);
      csr_wr(3'd0, 32'd1);
      csr_rd(3'd0, d);
      vectors++;
      if (d !== 32'd1) begin errs++; $display("FAIL busy_read: got %h want 1", d); end
      wait_idle(to);
      vectors++;
      if (to || rd_count - r0 !== 6 || wr_data !== 32'h0004_4000) begin
         errs++;
         $display("FAIL busy_run: got to=%0d rd=%0d data=%h want 0/6/00044000", to, rd_count - r0, wr_data);
      end
      csr_rd(3'd4, d);
      vectors++;
      if (d !== 32'd3) begin errs++; $display("FAIL busy_len_kept: got %h want 3", d); end
      csr_rd(3'd5, d);
      vectors++;
      if (d !== 32'h0000_4000) begin errs++; $display("FAIL busy_bias_kept: got %h want 00004000", d); end
   endtask

   task automatic test_reset_mid();
      bit to, hit;
      int r0, nrd, nwr;
      logic [31:0] d;
      stall_max = 0;
      lat_min = 5;
      lat_max = 5;
      load_basic();
      setup(32'h100, 32'h200, 32'h300, 3, 32'h0000_4000, 1);
      r0 = rd_count;
      csr_wr(3'd0, 32'd1);
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(negedge clk);
         hit = (rd_count - r0) >= 2;
      end
      vectors++;
      if (!hit) begin errs++; $display("FAIL rstmid_reach: got timeout want second read accepted"); end
      rst_n = 0;
      #1;
      vectors++;
      if ({master_read, master_write, master_address, master_writedata} !== 66'd0) begin
         errs++;
         $display("FAIL rstmid_outputs: got rd=%b wr=%b addr=%h data=%h want all 0", master_read, master_write, master_address, master_writedata);
      end
      for (int k = 0; k < 8; k++) begin
         csr_rd(3'(k), d);
         vectors++;
         if (d !== 32'd0) begin errs++; $display("FAIL rstmid_csr%0d: got %h want 0", k, d); end
      end
      @(negedge clk);
      rst_n = 1;
      lat_min = 1;
      lat_max = 3;
      setup(32'h100, 32'h200, 32'h300, 3, 32'h0000_4000, 0);
      run(to, nrd, nwr);
      vectors++;
      if (to || nrd !== 6 || nwr !== 1 || wr_data !== 32'h0004_4000) begin
         errs++;
         $display("FAIL rstmid_rerun: got to=%0d rd=%0d wr=%0d data=%h want 0/6/1/00044000", to, nrd, nwr, wr_data);
      end
   endtask

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = '0;
      #2 rst_n = 0;
      test_reset();
      @(negedge clk);
      rst_n = 1;
      test_basic();
      test_relu();
      test_len_zero();
      test_trunc();
      test_addr_wrap();
      test_stalls();
      test_busy_writes();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end
endmodule
